bit_sequencer3: RTL and testbench

- Upstream stimulus stage for the 3-bit greater-than-5 comparator.
- Steps a 3-bit code (bit2 MSB … bit0 LSB) through 0..LAST_CODE, holding each value for DWELL clocks; this is the RTL equivalent of the bench's timed #20 stepping.
- Samples the comparator's combinational result at the end of each dwell and counts hits.
- Signals completion with a one-cycle done pulse and supports single-pass or looping runs.

---
 rtl/bit_sequencer3.sv | 118 +++++++++++
 tb/tb_bit_sequencer3.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_sequencer3.sv
// Purpose: steps a 3-bit code 0..LAST_CODE, holds each code for DWELL clocks, and counts comparator hits.
// Latency: a new pass starts on the edge that samples start; done rises (LAST_CODE+1)*DWELL edges later.
// Backpressure: none; start is level-sampled in IDLE only, and stop aborts a run on any edge.
module bit_sequencer3 #(
    parameter int DWELL     = 20,
    parameter int DWELL_W   = 16,
    parameter int LAST_CODE = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    input  logic       result_in,
    output logic       bit0,
    output logic       bit1,
    output logic       bit2,
    output logic       valid,
    output logic       busy,
    output logic       done,
    output logic [3:0] hit_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Terminal values are sized once here, so the compares below stay width-clean.
    localparam logic [DWELL_W-1:0] DWELL_END = DWELL_W'(DWELL - 1);
    localparam logic [2:0]         CODE_END  = 3'(LAST_CODE);

    state_t             state;
    logic [2:0]         code;
    logic [DWELL_W-1:0] dwell_cnt;

    // The end of a dwell is the last cycle a code is held. At that point the comparator has settled.
    logic dwell_last;
    assign dwell_last = (dwell_cnt == DWELL_END);

    // The hit counter saturates: an increment is only allowed below 15.
    logic hit_inc;
    assign hit_inc = result_in && (hit_count != 4'hF);

    // Sequencer FSM. Every output is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            code      <= 3'd0;
            dwell_cnt <= '0;
            hit_count <= 4'd0;
            busy      <= 1'b0;
            valid     <= 1'b0;
            done      <= 1'b0;
        end else begin
            // done is a one-cycle pulse. Only the end-of-pass edge raises it.
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A simultaneous stop vetoes the start. The code keeps its last value while idle.
                    if (start && !stop) begin
                        state     <= ST_RUN;
                        code      <= 3'd0;
                        dwell_cnt <= '0;
                        hit_count <= 4'd0;
                        busy      <= 1'b1;
                        valid     <= 1'b1;
                    end
                end

                ST_RUN: begin
                    if (stop) begin
                        // An abort wins over an end of dwell on the same edge.
                        // No sample is taken, and no done pulse is raised.
                        state     <= ST_IDLE;
                        code      <= 3'd0;
                        dwell_cnt <= '0;
                        busy      <= 1'b0;
                        valid     <= 1'b0;
                    end else if (dwell_last) begin
                        dwell_cnt <= '0;
                        if (hit_inc) begin
                            hit_count <= hit_count + 4'd1;
                        end
                        if (code != CODE_END) begin
                            code <= code + 3'd1;
                        end else if (loop) begin
                            code <= 3'd0;
                        end else begin
                            // The pass is complete. The code is left showing LAST_CODE.
                            state <= ST_DONE;
                            busy  <= 1'b0;
                            valid <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + DWELL_W'(1);
                    end
                end

                ST_DONE: begin
                    // This state lasts one cycle. Any start held high is only seen once back in IDLE.
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bit0 = code[0];
    assign bit1 = code[1];
    assign bit2 = code[2];

endmodule

// File: tb/tb_bit_sequencer3.sv
// Bench for bit_sequencer3: three instances with different DWELL and LAST_CODE values.
// A pass-level model predicts the outputs, and a negedge process compares them every cycle.
// Directed scenarios add hand-computed literal expectations.
module tb_bit_sequencer3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Per-instance stimulus. Instance 0: DWELL=4, LAST=7. Instance 1: DWELL=1, LAST=7. Instance 2: DWELL=3, LAST=0.
    logic [2:0] start_v, stop_v, loop_v, rmode_v, rforce_v, res_v;
    logic [2:0] b0_v, b1_v, b2_v, vld_v, bsy_v, dn_v;
    logic [3:0] hc_v [3];

    int checks = 0;
    int errors = 0;

    // result_in is either forced, or comes from a ">5" comparator on that instance's bits.
    assign res_v[0] = rmode_v[0] ? rforce_v[0] : ({b2_v[0], b1_v[0], b0_v[0]} > 3'd5);
    assign res_v[1] = rmode_v[1] ? rforce_v[1] : ({b2_v[1], b1_v[1], b0_v[1]} > 3'd5);
    assign res_v[2] = rmode_v[2] ? rforce_v[2] : ({b2_v[2], b1_v[2], b0_v[2]} > 3'd5);

    bit_sequencer3 #(.DWELL(4), .DWELL_W(16), .LAST_CODE(7)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .stop(stop_v[0]), .loop(loop_v[0]),
        .result_in(res_v[0]), .bit0(b0_v[0]), .bit1(b1_v[0]), .bit2(b2_v[0]),
        .valid(vld_v[0]), .busy(bsy_v[0]), .done(dn_v[0]), .hit_count(hc_v[0]));

    bit_sequencer3 #(.DWELL(1), .DWELL_W(2), .LAST_CODE(7)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .stop(stop_v[1]), .loop(loop_v[1]),
        .result_in(res_v[1]), .bit0(b0_v[1]), .bit1(b1_v[1]), .bit2(b2_v[1]),
        .valid(vld_v[1]), .busy(bsy_v[1]), .done(dn_v[1]), .hit_count(hc_v[1]));

    bit_sequencer3 #(.DWELL(3), .DWELL_W(2), .LAST_CODE(0)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .stop(stop_v[2]), .loop(loop_v[2]),
        .result_in(res_v[2]), .bit0(b0_v[2]), .bit1(b1_v[2]), .bit2(b2_v[2]),
        .valid(vld_v[2]), .busy(bsy_v[2]), .done(dn_v[2]), .hit_count(hc_v[2]));

    // Pass-level model: k counts the cycles elapsed since the pass started.
    // The code is k / dwell, and a sample is taken on the last cycle of each dwell.
    typedef struct {
        bit run;
        bit done;
        int k;
        int code;
        int hits;
    } model_t;

    model_t mdl [3];
    int     dw_p [3] = '{4, 1, 3};
    int     lc_p [3] = '{7, 7, 0};

    task automatic step(inout model_t m, input int dw, input int lc,
                        input bit st, input bit sp, input bit lp, input bit rs);
        if (m.done) begin
            m.done = 1'b0;
        end else if (!m.run) begin
            if (st && !sp) begin
                m.run  = 1'b1;
                m.k    = 0;
                m.code = 0;
                m.hits = 0;
            end
        end else if (sp) begin
            m.run  = 1'b0;
            m.code = 0;
        end else begin
            if ((m.k % dw) == dw - 1) begin
                m.hits = (m.hits + int'(rs) > 15) ? 15 : m.hits + int'(rs);
            end
            m.k++;
            if (m.k == (lc + 1) * dw) begin
                if (lp) begin
                    m.k = 0;
                end else begin
                    m.run  = 1'b0;
                    m.done = 1'b1;
                end
            end
            if (m.run) begin
                m.code = m.k / dw;
            end
        end
    endtask

    // Advance the model on the same edges the DUT sees. Its reset is asynchronous, as in the DUT.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                mdl[i] = '{run: 1'b0, done: 1'b0, k: 0, code: 0, hits: 0};
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                step(mdl[i], dw_p[i], lc_p[i], start_v[i], stop_v[i], loop_v[i], res_v[i]);
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Compare every instance against the model on every falling edge.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("model_code%0d", i), {5'd0, b2_v[i], b1_v[i], b0_v[i]}, 8'(mdl[i].code));
            chk($sformatf("model_busy%0d", i), {7'd0, bsy_v[i]}, {7'd0, mdl[i].run});
            chk($sformatf("model_valid%0d", i), {7'd0, vld_v[i]}, {7'd0, mdl[i].run});
            chk($sformatf("model_done%0d", i), {7'd0, dn_v[i]}, {7'd0, mdl[i].done});
            chk($sformatf("model_hits%0d", i), {4'd0, hc_v[i]}, 8'(mdl[i].hits));
        end
    end

    // Literal expectations for one instance. valid is expected to match busy.
    task automatic lit(input string nm, input int i, input int code, input bit bsy,
                       input bit dn, input int hits);
        chk({nm, "_code"}, {5'd0, b2_v[i], b1_v[i], b0_v[i]}, 8'(code));
        chk({nm, "_busy"}, {7'd0, bsy_v[i]}, {7'd0, bsy});
        chk({nm, "_valid"}, {7'd0, vld_v[i]}, {7'd0, bsy});
        chk({nm, "_done"}, {7'd0, dn_v[i]}, {7'd0, dn});
        chk({nm, "_hits"}, {4'd0, hc_v[i]}, 8'(hits));
    endtask

    task automatic ticks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start a pass on instance i. Returns at the falling edge after the start-sampling edge (N0).
    task automatic kick(input int i);
        start_v[i] = 1'b1;
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        start_v  = '0;
        stop_v   = '0;
        loop_v   = '0;
        rmode_v  = '0;
        rforce_v = '0;

        ticks(2);
        lit("reset", 0, 0, 1'b0, 1'b0, 0);
        rst_n = 1'b1;
        ticks(1);

        // Single pass with the >5 comparator.
        kick(0);
        lit("p1_n0", 0, 0, 1'b1, 1'b0, 0);
        ticks(4);
        lit("p1_n4", 0, 1, 1'b1, 1'b0, 0);
        ticks(24);
        lit("p1_n28", 0, 7, 1'b1, 1'b0, 1);
        ticks(3);
        lit("p1_n31", 0, 7, 1'b1, 1'b0, 1);
        ticks(1);
        lit("p1_n32", 0, 7, 1'b0, 1'b1, 2);
        ticks(1);
        lit("p1_n33", 0, 7, 1'b0, 1'b0, 2);

        // start and stop together in IDLE: nothing moves.
        start_v[0] = 1'b1;
        stop_v[0]  = 1'b1;
        ticks(3);
        lit("ss_idle", 0, 7, 1'b0, 1'b0, 2);
        start_v[0] = 1'b0;
        stop_v[0]  = 1'b0;
        ticks(1);

        // start held through DONE: the next pass begins one edge after returning to IDLE.
        start_v[0] = 1'b1;
        ticks(1);
        ticks(32);
        lit("hold_n32", 0, 7, 1'b0, 1'b1, 2);
        ticks(1);
        lit("hold_n33", 0, 7, 1'b0, 1'b0, 2);
        ticks(1);
        lit("hold_n34", 0, 0, 1'b1, 1'b0, 0);
        start_v[0] = 1'b0;
        stop_v[0]  = 1'b1;
        ticks(1);
        lit("hold_stop", 0, 0, 1'b0, 1'b0, 0);
        stop_v[0] = 1'b0;
        ticks(1);

        // Looping: three passes, then an abort.
        loop_v[0] = 1'b1;
        kick(0);
        ticks(95);
        lit("loop_n95", 0, 7, 1'b1, 1'b0, 5);
        ticks(1);
        lit("loop_n96", 0, 0, 1'b1, 1'b0, 6);
        stop_v[0] = 1'b1;
        ticks(1);
        lit("loop_stop", 0, 0, 1'b0, 1'b0, 6);
        stop_v[0] = 1'b0;
        loop_v[0] = 1'b0;
        ticks(1);

        // Stop on the end-of-dwell edge of code 3 with result_in=1: only codes 0..2 are counted.
        rmode_v[0]  = 1'b1;
        rforce_v[0] = 1'b1;
        kick(0);
        ticks(15);
        stop_v[0] = 1'b1;
        ticks(1);
        lit("eod_stop", 0, 0, 1'b0, 1'b0, 3);
        stop_v[0] = 1'b0;
        ticks(2);

        // Asynchronous reset in the middle of code 5.
        kick(0);
        ticks(21);
        lit("pre_rst", 0, 5, 1'b1, 1'b0, 5);
        #2 rst_n = 1'b0;
        #1 lit("async_rst", 0, 0, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        kick(0);
        lit("post_rst_n0", 0, 0, 1'b1, 1'b0, 0);
        ticks(4);
        lit("post_rst_n4", 0, 1, 1'b1, 1'b0, 1);
        stop_v[0] = 1'b1;
        ticks(1);
        stop_v[0]  = 1'b0;
        rmode_v[0] = 1'b0;
        ticks(1);

        // DWELL=1, looping, result_in=1: the code advances every clock and hits saturate at 15.
        rmode_v[1]  = 1'b1;
        rforce_v[1] = 1'b1;
        loop_v[1]   = 1'b1;
        kick(1);
        lit("d1_n0", 1, 0, 1'b1, 1'b0, 0);
        ticks(1);
        lit("d1_n1", 1, 1, 1'b1, 1'b0, 1);
        ticks(13);
        lit("d1_n14", 1, 6, 1'b1, 1'b0, 14);
        ticks(1);
        lit("d1_n15", 1, 7, 1'b1, 1'b0, 15);
        ticks(5);
        lit("d1_n20", 1, 4, 1'b1, 1'b0, 15);
        stop_v[1] = 1'b1;
        ticks(1);
        lit("d1_stop", 1, 0, 1'b0, 1'b0, 15);
        stop_v[1] = 1'b0;
        loop_v[1] = 1'b0;

        // LAST_CODE=0, DWELL=3: a single code, with done after 3 cycles.
        rmode_v[2]  = 1'b1;
        rforce_v[2] = 1'b1;
        kick(2);
        lit("lc0_n0", 2, 0, 1'b1, 1'b0, 0);
        ticks(2);
        lit("lc0_n2", 2, 0, 1'b1, 1'b0, 0);
        ticks(1);
        lit("lc0_n3", 2, 0, 1'b0, 1'b1, 1);
        ticks(1);
        lit("lc0_n4", 2, 0, 1'b0, 1'b0, 1);
        ticks(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
